// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam int WAYS_MIN = 1;
    localparam int WAYS_MAX = 4;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    // Victim pointer keeps at least one bit so a direct-mapped build still has a legal vector
    function automatic int ptr_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic bit ways_ok(input int ways);
        return (ways == 1) || (ways == 2) || (ways == 4);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid flops with global clear, tag/data arrays with registered read.
module cache_way #(
    parameter int SETS   = 4,
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [IDX_W-1:0]  lk_idx,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              valid,
    output logic              match,
    output logic [DATA_W-1:0] rdata,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [SETS-1:0]   valid_reg;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_rd_reg;
    logic [DATA_W-1:0] data_rd_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else if (clr) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // Read is issued while the controller idles, so the entry is ready by lookup
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            tag_rd_reg  <= tag_mem[rd_idx];
            data_rd_reg <= data_mem[rd_idx];
        end
    end

    assign valid = valid_reg[lk_idx];
    assign match = valid && (tag_rd_reg == lk_tag);
    assign rdata = data_rd_reg;

endmodule

// File: rtl/cache_ctrl.sv
// Set-associative write-through, write-allocate data cache with miss handling FSM.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS);
    localparam int PTR_W = ptr_w(WAYS);

    generate
        if (!ways_ok(WAYS) || SETS < 2) begin : g_bad_param
            $error("cache_ctrl: unsupported WAYS/SETS");
        end
    endgenerate

    state_t state_reg, state_next;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [PTR_W-1:0]  victim_reg;
    logic              evict_reg;
    logic              hit_reg;
    logic              mem_req_reg, mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [PTR_W-1:0]  ptr_reg [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              flush;
    logic [WAYS-1:0]   way_valid, way_match, way_wr;
    logic [DATA_W-1:0] way_data [WAYS];

    logic              hit, all_valid;
    logic [PTR_W-1:0]  hit_way, first_inv, victim;
    logic [DATA_W-1:0] hit_data;

    logic              arr_we, ptr_adv;
    logic [PTR_W-1:0]  arr_way;
    logic [DATA_W-1:0] arr_data;

    assign idx   = addr_reg[IDX_W-1:0];
    assign tag   = addr_reg[ADDR_W-1:IDX_W];
    assign flush = (state_reg == IDLE) && cpu_flush;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_wr[gi] = arr_we && (arr_way == PTR_W'(gi));
            cache_way #(
                .SETS   (SETS),
                .IDX_W  (IDX_W),
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_way (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .rd_en   (state_reg == IDLE),
                .rd_idx  (cpu_addr[IDX_W-1:0]),
                .lk_idx  (idx),
                .lk_tag  (tag),
                .valid   (way_valid[gi]),
                .match   (way_match[gi]),
                .rdata   (way_data[gi]),
                .wr_en   (way_wr[gi]),
                .wr_idx  (idx),
                .wr_tag  (tag),
                .wr_data (arr_data)
            );
        end
    endgenerate

    // At most one way can match, so the last match found is the only one
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_match[i]) begin
                hit      = 1'b1;
                hit_way  = PTR_W'(i);
                hit_data = way_data[i];
            end
        end
    end

    always_comb begin
        first_inv = '0;
        all_valid = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                first_inv = PTR_W'(i);
                all_valid = 1'b0;
            end
        end
        victim = all_valid ? ptr_reg[idx] : first_inv;
    end

    always_comb begin
        state_next = state_reg;
        cpu_ready  = 1'b0;
        cpu_hit    = 1'b0;
        cpu_rdata  = '0;
        arr_we     = 1'b0;
        arr_way    = '0;
        arr_data   = wdata_reg;
        ptr_adv    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cpu_flush && cpu_req) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (we_reg) begin
                    arr_we     = 1'b1;
                    arr_way    = hit ? hit_way : victim;
                    ptr_adv    = !hit && all_valid;
                    state_next = MEM_WR;
                end else if (hit) begin
                    cpu_ready  = 1'b1;
                    cpu_hit    = 1'b1;
                    cpu_rdata  = hit_data;
                    state_next = IDLE;
                end else begin
                    state_next = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    arr_we     = 1'b1;
                    arr_way    = victim_reg;
                    arr_data   = mem_rdata;
                    ptr_adv    = evict_reg;
                    cpu_ready  = 1'b1;
                    cpu_rdata  = mem_rdata;
                    state_next = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    cpu_ready  = 1'b1;
                    cpu_hit    = hit_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            victim_reg    <= '0;
            evict_reg     <= 1'b0;
            hit_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && cpu_req && !cpu_flush) begin
                we_reg    <= cpu_we;
                addr_reg  <= cpu_addr;
                wdata_reg <= cpu_wdata;
            end
            if (state_reg == LOOKUP) begin
                victim_reg <= victim;
                evict_reg  <= !hit && all_valid;
                hit_reg    <= hit;
                if (state_next != IDLE) begin
                    mem_req_reg   <= 1'b1;
                    mem_we_reg    <= we_reg;
                    mem_addr_reg  <= addr_reg;
                    mem_wdata_reg <= we_reg ? wdata_reg : '0;
                end
            end
            if ((state_reg == MEM_RD || state_reg == MEM_WR) && mem_ack) begin
                mem_req_reg   <= 1'b0;
                mem_we_reg    <= 1'b0;
                mem_addr_reg  <= '0;
                mem_wdata_reg <= '0;
            end
        end
    end

    // Round-robin pointer only moves when a fully valid set loses a line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
        end else if (ptr_adv && WAYS > 1) begin
            ptr_reg[idx] <= ptr_reg[idx] + PTR_W'(1);
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (cpu_ready) begin
            if (cpu_hit) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            else         miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: stimulus queues expected responses, monitor and memory model check them.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready, cpu_hit;
    logic [15:0] cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_flush (cpu_flush),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_hit   (cpu_hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    typedef struct {
        logic [15:0] rdata;
        logic        hit;
        logic        chk_rdata;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   pass_cnt = 0;
    int   total    = 0;
    bit   mem_hold = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst && cpu_ready) begin
                if (rsp_q.size() == 0) begin
                    check("spurious_ready", 32'(cpu_ready), 32'(0));
                end else begin
                    r = rsp_q.pop_front();
                    $display("txn ready rdata=%h hit=%b", cpu_rdata, cpu_hit);
                    if (r.chk_rdata) check("rdata", 32'(cpu_rdata), 32'(r.rdata));
                    check("hit", 32'(cpu_hit), 32'(r.hit));
                end
            end
        end
    end

    // Memory model: acks each request one cycle after it appears
    initial begin
        mem_t m;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end else if (rst && mem_req && !mem_hold) begin
                if (mem_q.size() == 0) begin
                    check("spurious_mem_req", 32'(mem_req), 32'(0));
                end else begin
                    m = mem_q.pop_front();
                    $display("txn mem we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    check("mem_wdata", 32'(mem_wdata), m.we ? 32'(m.wdata) : 32'(0));
                    mem_rdata = m.rdata;
                end
                mem_ack = 1'b1;
            end
        end
    end

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                          input logic exp_mem, input logic [15:0] mem_data,
                          input logic [15:0] exp_rdata, input logic exp_hit, input int exp_lat);
        rsp_t r;
        mem_t m;
        int   n;
        if (exp_mem) begin
            m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = mem_data;
            mem_q.push_back(m);
        end
        r.rdata = exp_rdata; r.hit = exp_hit; r.chk_rdata = !we;
        rsp_q.push_back(r);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 20);
        check("latency", 32'(n), 32'(exp_lat));
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        cpu_flush = 1'b1;
        @(negedge clk);
        cpu_flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'(0));
        check("rst_cpu_hit", 32'(cpu_hit), 32'(0));
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'(0));
        check("rst_miss_cnt", miss_cnt, 32'(0));
`endif
        rst = 1'b1;
        @(negedge clk);

        // read miss then hit of 0x05
        do_req(1'b0, 8'h05, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 2);
        do_req(1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1);
        // write miss allocates way 1 of set 1, then read hit
        do_req(1'b1, 8'h09, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0, 2);
        do_req(1'b0, 8'h09, 16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1);
`ifdef CACHE_STATS_EN
        check("stat_hit_cnt", hit_cnt, 32'd2);
        check("stat_miss_cnt", miss_cnt, 32'd2);
`endif
        // write hit updates the line and still goes to memory
        do_req(1'b1, 8'h05, 16'h7777, 1'b1, 16'h0000, 16'h0000, 1'b1, 2);
        do_req(1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 16'h7777, 1'b1, 1);

        // flush forces a refetch
        do_flush();
        do_req(1'b0, 8'h05, 16'h0000, 1'b1, 16'hCAFE, 16'hCAFE, 1'b0, 2);

        // round-robin eviction in set 1 from an empty cache
        do_flush();
        do_req(1'b0, 8'h01, 16'h0000, 1'b1, 16'h0101, 16'h0101, 1'b0, 2);
        do_req(1'b0, 8'h05, 16'h0000, 1'b1, 16'h0505, 16'h0505, 1'b0, 2);
        do_req(1'b0, 8'h09, 16'h0000, 1'b1, 16'h0909, 16'h0909, 1'b0, 2);
        do_req(1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 16'h0505, 1'b1, 1);
        do_req(1'b0, 8'h01, 16'h0000, 1'b1, 16'h1111, 16'h1111, 1'b0, 2);
        do_req(1'b0, 8'h09, 16'h0000, 1'b0, 16'h0000, 16'h0909, 1'b1, 1);
        do_req(1'b0, 8'h01, 16'h0000, 1'b0, 16'h0000, 16'h1111, 1'b1, 1);
        do_req(1'b0, 8'h02, 16'h0000, 1'b1, 16'h2222, 16'h2222, 1'b0, 2);
        do_req(1'b0, 8'h02, 16'h0000, 1'b0, 16'h0000, 16'h2222, 1'b1, 1);

        // reset while a fill is outstanding
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_mem_req", 32'(mem_req), 32'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'(0));
        check("rst_mid_ready", 32'(cpu_ready), 32'(0));
        cpu_req = 1'b0; cpu_addr = '0;
        @(negedge clk);
        rst = 1'b1;
        mem_hold = 1'b0;
`ifdef CACHE_STATS_EN
        check("rst_mid_hit_cnt", hit_cnt, 32'(0));
`endif
        do_req(1'b0, 8'h05, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A, 1'b0, 2);
        do_req(1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 1);

        repeat (3) @(negedge clk);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'(0));
        check("mem_q_drained", 32'(mem_q.size()), 32'(0));
        check("idle_mem_req", 32'(mem_req), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Parametrised set-associative, write-through, write-allocate data cache with its own miss-handling state machine. It sits between the pipeline's memory stage and data memory. It replaces the unclocked two-way lookup array with a clocked block that:
- serves hits from its arrays;
- fetches misses over a request/acknowledge handshake;
- forwards every store to memory.

## Interface
- ADDR_W, 8: word-address width.
- DATA_W, 16: data word width; one word per line.
- SETS, 4: set count, power of two, ≥2; index = addr[log2(SETS)-1:0].
- WAYS, 2: associativity, one of 1, 2, 4.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  request, sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_flush  in  1  invalidate all lines, sampled only in IDLE.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  load data, valid with cpu_ready.
- cpu_hit  out  1  request served from cache, valid with cpu_ready.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- hit_cnt, miss_cnt  out  32 each  only with CACHE_STATS_EN.

## Operation
- Tag = addr[ADDR_W-1:log2(SETS)]. Each way holds valid, tag and data per set.
- Each set has a round-robin victim pointer of log2(WAYS) bits.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR.
- IDLE:
  - cpu_flush takes priority: all valid bits and pointers clear in one cycle; stay IDLE; no cpu_ready.
  - Otherwise cpu_req latches we/addr/wdata → LOOKUP.
- LOOKUP, read hit: cpu_ready=1, cpu_hit=1, cpu_rdata = hitting way → IDLE.
- LOOKUP, read miss → MEM_RD.
- LOOKUP, write hit: update the hitting way's data → MEM_WR.
- LOOKUP, write miss: allocate a victim (valid=1, tag, data) → MEM_WR.
- MEM_RD:
  - Drive mem_req=1, mem_we=0, mem_addr = latched address.
  - On mem_ack: fill the victim; cpu_ready=1, cpu_hit=0, cpu_rdata = mem_rdata → IDLE.
- MEM_WR:
  - Drive mem_req=1, mem_we=1, mem_addr and mem_wdata = latched values.
  - On mem_ack: cpu_ready=1, cpu_hit = whether LOOKUP hit → IDLE.
- Victim choice:
  - Lowest-index invalid way.
  - If all ways are valid, the way at the set pointer; the pointer then increments mod WAYS.
  - Hits never move the pointer. WAYS=1 always uses way 0.
- Multiple matching ways cannot occur; allocation only happens on a miss.
- The requester holds request signals until cpu_ready. It must drop cpu_req, or present the next request, in the cycle after cpu_ready.

## Timing
- Read hit: cpu_ready 2 cycles after cpu_req is sampled.
- Miss or write: cpu_ready in the cycle mem_ack is seen; minimum 3 cycles.
- mem_* outputs are registered, stable while mem_req=1, and 0 when idle.
- Array updates take effect at the edge leaving LOOKUP (write) or MEM_RD (fill).
- Reset values: state IDLE; all valid bits 0; pointers 0; every output 0, including counters.
- Reset mid-operation: mem_req drops immediately and any pending cpu_ready is lost. The memory side tolerates an abandoned transaction.

## Configuration
- CACHE_STATS_EN defined:
  - hit_cnt increments on every cpu_ready with cpu_hit=1.
  - miss_cnt increments on every cpu_ready with cpu_hit=0.
  - Both wrap at 2^32. Neither changes on flush.
- CACHE_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package cache_pkg holds:
  - the state enum;
  - the clog2-based width functions (index and tag width);
  - the allowed WAYS values.
- Sub-module cache_way: one per way, generated WAYS times. It holds valid/tag/data for SETS entries and provides:
  - combinational tag-match output;
  - write port for allocate and update;
  - global clear for flush and reset.

## Test plan
All with default parameters.
1. Reset, then read 0x05 → mem_req rd 0x05; ack with 0xBEEF → cpu_ready, rdata 0xBEEF, hit 0. Read 0x05 again → ready 2 cycles after request, rdata 0xBEEF, hit 1, no mem_req.
2. Write 0x09 = 0x1234 → mem_req wr 0x09/0x1234; after ack, hit 0. Read 0x09 → hit 1, rdata 0x1234, no mem_req.
3. Read-miss 0x01, 0x05, then 0x09 (all set 1): 0x09 evicts way 0 (0x01). Then read 0x05 → hit; read 0x01 → miss, evicting way 1 (0x05).
4. After test 1, pulse cpu_flush in IDLE → read 0x05 misses (mem_req asserted).
5. Assert rst during MEM_RD before mem_ack → mem_req 0 immediately, no cpu_ready. After release, read 0x05 misses.
6. With CACHE_STATS_EN, run test 1 then test 2 → hit_cnt 2, miss_cnt 2.
